// File: rtl/sa_mover_ctrl.sv
// Tile sequencer for the systolic-array mover: FILL rows, STREAM window, DRAIN skew, per output tile.
// Latency: all outputs registered; unstalled tile period PE_SIZE+1+STREAM_LEN+2*PE_SIZE-1 cycles.
// Backpressure: fifo_full_i stalls FILL reads only; optional stall counter under SA_MOVER_CTRL_PERF_EN.
module sa_mover_ctrl #(
    parameter int PE_SIZE        = 14,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int STREAM_LEN     = 69,
    parameter int NUM_TILES      = 5,
    parameter int TILE_STRIDE    = 14,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      mem_rden_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                      fifo_full_i,
    output logic                      fifo_wren_o,
    output logic                      mover_en_o,
    output logic [CNT_WIDTH-1:0]      tile_idx_o
`ifdef SA_MOVER_CTRL_PERF_EN
    ,
    output logic [31:0]               stall_cnt_o
`endif
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FILL      = 3'd1;
    localparam logic [2:0] S_FILL_WAIT = 3'd2;
    localparam logic [2:0] S_STREAM    = 3'd3;
    localparam logic [2:0] S_DRAIN     = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam logic [CNT_WIDTH-1:0]      CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]      ROW_LAST    = CNT_WIDTH'(PE_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0]      STREAM_LAST = CNT_WIDTH'(STREAM_LEN - 1);
    localparam logic [CNT_WIDTH-1:0]      DRAIN_LAST  = CNT_WIDTH'(2 * PE_SIZE - 2);
    localparam logic [CNT_WIDTH-1:0]      TILE_LAST   = CNT_WIDTH'(NUM_TILES - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE    = MEM_ADDR_WIDTH'(1);
    localparam logic [MEM_ADDR_WIDTH-1:0] STRIDE      = MEM_ADDR_WIDTH'(TILE_STRIDE);

    logic [2:0]                state;
    logic [CNT_WIDTH-1:0]      row_cnt;
    logic [CNT_WIDTH-1:0]      phase_cnt;
    logic [MEM_ADDR_WIDTH-1:0] tile_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            mem_rden_o  <= 1'b0;
            mem_addr_o  <= '0;
            fifo_wren_o <= 1'b0;
            mover_en_o  <= 1'b0;
            tile_idx_o  <= '0;
            row_cnt     <= '0;
            phase_cnt   <= '0;
            tile_base   <= '0;
        end else begin
            done_o      <= 1'b0;
            mem_rden_o  <= 1'b0;
            mover_en_o  <= 1'b0;
            // Memory returns data one cycle after the read, so the FIFO write trails it.
            fifo_wren_o <= mem_rden_o;
            // Address advances after each visible read; a stalled cycle leaves it pointing at the next row.
            if (mem_rden_o) begin
                mem_addr_o <= mem_addr_o + ADDR_ONE;
            end
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state      <= S_FILL;
                        busy_o     <= 1'b1;
                        tile_base  <= base_addr_i;
                        mem_addr_o <= base_addr_i;
                        tile_idx_o <= '0;
                        row_cnt    <= '0;
                    end
                end
                S_FILL: begin
                    if (!fifo_full_i) begin
                        mem_rden_o <= 1'b1;
                        row_cnt    <= row_cnt + CNT_ONE;
                        if (row_cnt == ROW_LAST) begin
                            state <= S_FILL_WAIT;
                        end
                    end
                end
                S_FILL_WAIT: begin
                    state      <= S_STREAM;
                    mover_en_o <= 1'b1;
                    phase_cnt  <= '0;
                end
                S_STREAM: begin
                    if (phase_cnt == STREAM_LAST) begin
                        state     <= S_DRAIN;
                        phase_cnt <= '0;
                    end else begin
                        mover_en_o <= 1'b1;
                        phase_cnt  <= phase_cnt + CNT_ONE;
                    end
                end
                S_DRAIN: begin
                    if (phase_cnt == DRAIN_LAST) begin
                        if (tile_idx_o == TILE_LAST) begin
                            state <= S_DONE;
                        end else begin
                            state      <= S_FILL;
                            tile_idx_o <= tile_idx_o + CNT_ONE;
                            tile_base  <= tile_base + STRIDE;
                            mem_addr_o <= tile_base + STRIDE;
                            row_cnt    <= '0;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CNT_ONE;
                    end
                end
                S_DONE: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SA_MOVER_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (state == S_IDLE && start_i) begin
            stall_cnt_o <= '0;
        end else if (state == S_FILL && fifo_full_i && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sa_mover_ctrl.sv
// Bench for sa_mover_ctrl: randomized jobs checked against a schedule model built from tile timing rules.
module tb_sa_mover_ctrl;
    localparam int PE_SIZE = 14, AW = 10, STREAM_LEN = 69, NUM_TILES = 5, TILE_STRIDE = 14, CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic          fifo_full_i = 1'b0;
    logic          busy_o, done_o, mem_rden_o, fifo_wren_o, mover_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [CW-1:0] tile_idx_o;
`ifdef SA_MOVER_CTRL_PERF_EN
    logic [31:0]   stall_cnt_o;
`endif

    sa_mover_ctrl #(
        .PE_SIZE(PE_SIZE), .MEM_ADDR_WIDTH(AW), .STREAM_LEN(STREAM_LEN),
        .NUM_TILES(NUM_TILES), .TILE_STRIDE(TILE_STRIDE), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .busy_o(busy_o), .done_o(done_o), .mem_rden_o(mem_rden_o), .mem_addr_o(mem_addr_o),
        .fifo_full_i(fifo_full_i), .fifo_wren_o(fifo_wren_o), .mover_en_o(mover_en_o),
        .tile_idx_o(tile_idx_o)
`ifdef SA_MOVER_CTRL_PERF_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Observations, indexed by posedges after the start-sampling edge.
    int            rd_cyc[$];
    logic [AW-1:0] rd_addr[$];
    int            rd_tile[$];
    int            wr_cyc[$];
    int            mv_cyc[$];
    int            mv_tile[$];
    int            done_cyc, overlap, xcnt, busy_err, act_after;
    logic          busy_at_done, done_after;
    logic [4:0]    rst_bits;
    logic [AW-1:0] rst_addr;
    logic [CW-1:0] rst_tile;
    logic [31:0]   stall_at_done, stall_after;

    // Expected schedule
    int            exp_rd_cyc[$];
    logic [AW-1:0] exp_rd_addr[$];
    int            exp_rd_tile[$];
    int            exp_mv_cyc[$];
    int            exp_mv_tile[$];
    int            exp_done;

    // A tile reads PE_SIZE rows on non-stalled edges, then 1 wait + STREAM_LEN stream + 2*PE_SIZE-1 drain
    // cycles; the next tile's first read lands one edge after the drain ends.
    task automatic build_model(input logic [AW-1:0] base, input int stall_at, input int stall_len);
        int e;
        int last;
        logic [AW-1:0] a;
        exp_rd_cyc.delete(); exp_rd_addr.delete(); exp_rd_tile.delete();
        exp_mv_cyc.delete(); exp_mv_tile.delete();
        e = 1;
        for (int t = 0; t < NUM_TILES; t++) begin
            int r;
            r = 0;
            while (r < PE_SIZE) begin
                if (!(e >= stall_at && e < stall_at + stall_len)) begin
                    a = base + AW'(t * TILE_STRIDE + r);
                    exp_rd_cyc.push_back(e);
                    exp_rd_addr.push_back(a);
                    exp_rd_tile.push_back(t);
                    r++;
                end
                e++;
            end
            last = e - 1;
            for (int m = 1; m <= STREAM_LEN; m++) begin
                exp_mv_cyc.push_back(last + m);
                exp_mv_tile.push_back(t);
            end
            e = last + 1 + STREAM_LEN + (2 * PE_SIZE - 1) + 1;
        end
        exp_done = e;
    endtask

    function automatic int sched_errs();
        int n;
        n = 0;
        if (rd_cyc.size() != exp_rd_cyc.size()) n++;
        else foreach (rd_cyc[i]) begin
            if (rd_cyc[i] != exp_rd_cyc[i]) n++;
            if (rd_addr[i] !== exp_rd_addr[i]) n++;
            if (rd_tile[i] != exp_rd_tile[i]) n++;
        end
        if (wr_cyc.size() != rd_cyc.size()) n++;
        else foreach (wr_cyc[i]) if (wr_cyc[i] != rd_cyc[i] + 1) n++;
        if (mv_cyc.size() != exp_mv_cyc.size()) n++;
        else foreach (mv_cyc[i]) begin
            if (mv_cyc[i] != exp_mv_cyc[i]) n++;
            if (mv_tile[i] != exp_mv_tile[i]) n++;
        end
        return n;
    endfunction

    task automatic run_job(input logic [AW-1:0] base, input int stall_at, input int stall_len,
                           input int spur_at, input int rst_at);
        rd_cyc.delete(); rd_addr.delete(); rd_tile.delete();
        wr_cyc.delete(); mv_cyc.delete(); mv_tile.delete();
        done_cyc = -1; overlap = 0; xcnt = 0; busy_err = 0; act_after = 0;
        busy_at_done = 1'bx; done_after = 1'bx;
        stall_at_done = '0; stall_after = '0;
        @(negedge clk);
        base_addr_i = base;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        base_addr_i = AW'($urandom);
        for (int k = 0; k < 1500; k++) begin
            if ($isunknown({busy_o, done_o, mem_rden_o, mem_addr_o, fifo_wren_o, mover_en_o, tile_idx_o})) xcnt++;
            if (mem_rden_o === 1'b1) begin
                rd_cyc.push_back(k); rd_addr.push_back(mem_addr_o); rd_tile.push_back(int'(tile_idx_o));
            end
            if (fifo_wren_o === 1'b1) wr_cyc.push_back(k);
            if (mover_en_o === 1'b1) begin
                mv_cyc.push_back(k); mv_tile.push_back(int'(tile_idx_o));
            end
            if (mem_rden_o === 1'b1 && mover_en_o === 1'b1) overlap++;
            if (rst_at >= 0 && k == rst_at) begin
                rst_bits = {busy_o, done_o, mem_rden_o, fifo_wren_o, mover_en_o};
                rst_addr = mem_addr_o;
                rst_tile = tile_idx_o;
            end
            if (rst_at >= 0 && k > rst_at && (busy_o | done_o | mem_rden_o | fifo_wren_o | mover_en_o) !== 1'b0)
                act_after++;
            if (rst_at >= 0 && k == rst_at + 6) break;
            if (done_o === 1'b1) begin
                done_cyc = k;
                busy_at_done = busy_o;
`ifdef SA_MOVER_CTRL_PERF_EN
                stall_at_done = stall_cnt_o;
`endif
                break;
            end
            if ((rst_at < 0 || k < rst_at) && busy_o !== 1'b1) busy_err++;
            fifo_full_i = (k + 1 >= stall_at && k + 1 < stall_at + stall_len);
            start_i = (k + 1 == spur_at);
            rst = (k + 1 == rst_at);
            @(posedge clk);
            @(negedge clk);
        end
        fifo_full_i = 1'b0;
        start_i = 1'b0;
        rst = 1'b0;
        if (done_cyc >= 0) begin
            @(posedge clk);
            @(negedge clk);
            done_after = done_o;
`ifdef SA_MOVER_CTRL_PERF_EN
            stall_after = stall_cnt_o;
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({busy_o, done_o, mem_rden_o, fifo_wren_o, mover_en_o} !== 5'b0) begin
            fails++; $display("FAIL reset_bits: got %b expected 00000", {busy_o, done_o, mem_rden_o, fifo_wren_o, mover_en_o});
        end
        tests++;
        if (mem_addr_o !== '0) begin
            fails++; $display("FAIL reset_addr: got %h expected 0", mem_addr_o);
        end
        tests++;
        if (tile_idx_o !== '0) begin
            fails++; $display("FAIL reset_tile: got %0d expected 0", tile_idx_o);
        end
        rst = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        run_job('0, -1, 0, -1, -1);
        build_model('0, -1, 0);
        tests++;
        if (done_cyc !== 556) begin fails++; $display("FAIL nominal_done: got %0d expected 556", done_cyc); end
        tests++;
        if (rd_cyc.size() !== 70 || wr_cyc.size() !== 70) begin
            fails++; $display("FAIL nominal_counts: reads %0d writes %0d expected 70/70", rd_cyc.size(), wr_cyc.size());
        end
        tests++;
        if (mv_cyc.size() !== 5 * 69) begin fails++; $display("FAIL nominal_mover: got %0d expected 345", mv_cyc.size()); end
        tests++;
        if (sched_errs() !== 0) begin fails++; $display("FAIL nominal_sched: got %0d mismatches expected 0", sched_errs()); end
        tests++;
        if (overlap !== 0 || busy_err !== 0 || xcnt !== 0) begin
            fails++; $display("FAIL nominal_flags: overlap %0d busy_err %0d x %0d expected 0", overlap, busy_err, xcnt);
        end
        tests++;
        if (busy_at_done !== 1'b0 || done_after !== 1'b0) begin
            fails++; $display("FAIL nominal_done_pulse: busy %b done_next %b expected 0/0", busy_at_done, done_after);
        end
    endtask

    task automatic test_addr();
        run_job(10'h010, -1, 0, -1, -1);
        build_model(10'h010, -1, 0);
        tests++;
        if (sched_errs() !== 0) begin fails++; $display("FAIL addr_sched: got %0d mismatches expected 0", sched_errs()); end
        tests++;
        if (rd_addr.size() != 70 || rd_addr[13] !== 10'h01D || rd_addr[14] !== 10'h01E || rd_addr[56] !== 10'h048 || rd_addr[69] !== 10'h055) begin
            fails++; $display("FAIL addr_points: got %0d reads, expected 0x1D,0x1E,0x48,0x55 at 13,14,56,69", rd_addr.size());
        end
    endtask

    task automatic test_stall();
        int s;
        int in_win;
        logic [AW-1:0] b;
        s = $urandom_range(3, 10);
        b = AW'($urandom);
        run_job(b, s, 3, -1, -1);
        build_model(b, s, 3);
        in_win = 0;
        foreach (rd_cyc[i]) if (rd_cyc[i] >= s && rd_cyc[i] < s + 3) in_win++;
        tests++;
        if (done_cyc !== 559) begin fails++; $display("FAIL stall_done: got %0d expected 559", done_cyc); end
        tests++;
        if (in_win !== 0) begin fails++; $display("FAIL stall_no_read: got %0d reads in stall expected 0", in_win); end
        tests++;
        if (wr_cyc.size() !== 70) begin fails++; $display("FAIL stall_writes: got %0d expected 70", wr_cyc.size()); end
        tests++;
        if (sched_errs() !== 0) begin fails++; $display("FAIL stall_sched: got %0d mismatches expected 0", sched_errs()); end
`ifdef SA_MOVER_CTRL_PERF_EN
        tests++;
        if (stall_at_done !== 32'd3 || stall_after !== 32'd3) begin
            fails++; $display("FAIL stall_cnt: got %0d/%0d expected 3/3", stall_at_done, stall_after);
        end
`endif
    endtask

    task automatic test_wrap();
        run_job(10'h3F8, -1, 0, -1, -1);
        build_model(10'h3F8, -1, 0);
        tests++;
        if (rd_addr.size() < 14 || rd_addr[7] !== 10'h3FF || rd_addr[8] !== 10'h000 || rd_addr[13] !== 10'h005) begin
            fails++; $display("FAIL wrap_points: got %0d reads, expected 0x3FF,0x000,0x005 at 7,8,13", rd_addr.size());
        end
        tests++;
        if (xcnt !== 0 || sched_errs() !== 0) begin
            fails++; $display("FAIL wrap_sched: x %0d mismatches %0d expected 0/0", xcnt, sched_errs());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int s;
            int l;
            logic [AW-1:0] b;
            s = $urandom_range(1, 130);
            l = $urandom_range(0, 6);
            b = AW'($urandom);
            run_job(b, s, l, -1, -1);
            build_model(b, s, l);
            tests++;
            if (done_cyc !== exp_done) begin fails++; $display("FAIL rand_done[%0d]: got %0d expected %0d", it, done_cyc, exp_done); end
            tests++;
            if (sched_errs() !== 0 || overlap !== 0) begin
                fails++; $display("FAIL rand_sched[%0d]: mismatches %0d overlap %0d expected 0/0", it, sched_errs(), overlap);
            end
`ifdef SA_MOVER_CTRL_PERF_EN
            tests++;
            if (stall_at_done !== 32'(exp_done - 556)) begin
                fails++; $display("FAIL rand_stall_cnt[%0d]: got %0d expected %0d", it, stall_at_done, exp_done - 556);
            end
`endif
        end
    endtask

    task automatic test_ignore_start();
        int p;
        p = $urandom_range(20, 80);
        run_job(10'h155, -1, 0, p, -1);
        build_model(10'h155, -1, 0);
        tests++;
        if (done_cyc !== 556) begin fails++; $display("FAIL ignore_done: got %0d expected 556", done_cyc); end
        tests++;
        if (sched_errs() !== 0) begin fails++; $display("FAIL ignore_sched: got %0d mismatches expected 0", sched_errs()); end
    endtask

    task automatic test_reset_mid();
        run_job(10'h0A0, -1, 0, -1, 40);
        tests++;
        if (rst_bits !== 5'b0 || rst_addr !== '0 || rst_tile !== '0) begin
            fails++; $display("FAIL midrst_outputs: bits %b addr %h tile %0d expected 0", rst_bits, rst_addr, rst_tile);
        end
        tests++;
        if (act_after !== 0) begin fails++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", act_after); end
        run_job(10'h0A0, -1, 0, -1, -1);
        build_model(10'h0A0, -1, 0);
        tests++;
        if (done_cyc !== 556 || sched_errs() !== 0) begin
            fails++; $display("FAIL midrst_rerun: done %0d mismatches %0d expected 556/0", done_cyc, sched_errs());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_addr();
        test_stall();
        test_wrap();
        test_random();
        test_ignore_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
